// File: rtl/riscv_idex_pipe_pkg.sv
// Shared configuration for the ID/EX pipeline slice: datapath width, register
// index width, ALU op codes, operand-source encodings, FSM states and the
// forwarding hit test used by both the mux and the stall-refresh logic.
package riscv_idex_pipe_pkg;

  localparam int CFG_XLEN   = 32;
  localparam int REG_AW     = 5;
  localparam int ALU_CTRL_W = 5;

  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_ADD  = 5'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SUB  = 5'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SLL  = 5'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SLT  = 5'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SLTU = 5'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_XOR  = 5'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SRL  = 5'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SRA  = 5'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_OR   = 5'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_AND  = 5'd9;

  // Operand A source: register or PC; operand B source: register or immediate.
  localparam logic ALU_SRC_A_RS1 = 1'b0;
  localparam logic ALU_SRC_A_PC  = 1'b1;
  localparam logic ALU_SRC_B_RS2 = 1'b0;
  localparam logic ALU_SRC_B_IMM = 1'b1;

  // Valid-bit FSM of the EX entry.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // A later stage supplies the operand when it writes the same register;
  // x0 is hard-wired to zero and is never forwarded.
  function automatic logic fwd_hit(input logic             wen,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs);
    return wen && (rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/riscv_fwd_mux.sv
// Per-operand bypass mux: MEM result beats WB result beats the register value
// captured at ID.
module riscv_fwd_mux
  import riscv_idex_pipe_pkg::*;
#(
  parameter int XLEN = CFG_XLEN
) (
  input  logic [REG_AW-1:0] i_rs_addr,
  input  logic [XLEN-1:0]   i_rs_data,
  input  logic [REG_AW-1:0] i_mem_rd_addr,
  input  logic              i_mem_reg_wen,
  input  logic [XLEN-1:0]   i_mem_result,
  input  logic [REG_AW-1:0] i_wb_rd_addr,
  input  logic              i_wb_reg_wen,
  input  logic [XLEN-1:0]   i_wb_result,
  output logic [XLEN-1:0]   o_data
);

  // Pick the youngest in-flight producer of the operand, if any.
  always_comb begin
    o_data = i_rs_data;
    if (fwd_hit(i_mem_reg_wen, i_mem_rd_addr, i_rs_addr)) begin
      o_data = i_mem_result;
    end else if (fwd_hit(i_wb_reg_wen, i_wb_rd_addr, i_rs_addr)) begin
      o_data = i_wb_result;
    end
  end

endmodule

// File: rtl/riscv_idex_pipe.sv
// ID/EX pipeline register with a one-entry valid/ready handshake, flush,
// operand forwarding from MEM/WB and refresh of held operands during stalls.
module riscv_idex_pipe
  import riscv_idex_pipe_pkg::*;
#(
  parameter int XLEN = CFG_XLEN
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_id_valid,
  output logic                  o_id_ready,
  input  logic [XLEN-1:0]       i_id_pc,
  input  logic [XLEN-1:0]       i_id_rs1_data,
  input  logic [XLEN-1:0]       i_id_rs2_data,
  input  logic [XLEN-1:0]       i_id_imm,
  input  logic [REG_AW-1:0]     i_id_rs1_addr,
  input  logic [REG_AW-1:0]     i_id_rs2_addr,
  input  logic [REG_AW-1:0]     i_id_rd_addr,
  input  logic [ALU_CTRL_W-1:0] i_id_alu_ctrl,
  input  logic                  i_id_alu_src_a,
  input  logic                  i_id_alu_src_b,
  input  logic                  i_id_reg_wen,
  input  logic                  i_ex_ready,
  input  logic [REG_AW-1:0]     i_mem_rd_addr,
  input  logic                  i_mem_reg_wen,
  input  logic [XLEN-1:0]       i_mem_result,
  input  logic [REG_AW-1:0]     i_wb_rd_addr,
  input  logic                  i_wb_reg_wen,
  input  logic [XLEN-1:0]       i_wb_result,
  output logic                  o_ex_valid,
  output logic [XLEN-1:0]       o_alu_a,
  output logic [XLEN-1:0]       o_alu_b,
  output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
  output logic [XLEN-1:0]       o_ex_rs2_data,
  output logic [XLEN-1:0]       o_ex_pc,
  output logic [REG_AW-1:0]     o_ex_rd_addr,
  output logic                  o_ex_reg_wen
);

  logic [0:0]            r_state;
  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [XLEN-1:0]       r_imm;
  logic [REG_AW-1:0]     r_rs1_addr;
  logic [REG_AW-1:0]     r_rs2_addr;
  logic [REG_AW-1:0]     r_rd_addr;
  logic [ALU_CTRL_W-1:0] r_alu_ctrl;
  logic                  r_alu_src_a;
  logic                  r_alu_src_b;
  logic                  r_reg_wen;

  logic                  w_full;
  logic                  w_accept;
  logic                  w_hold;
  logic [REG_AW-1:0]     w_rs_addr [2];
  logic [XLEN-1:0]       w_rs_data [2];
  logic [XLEN-1:0]       w_fwd     [2];

  assign w_full     = (r_state == ST_FULL);
  assign o_id_ready = !w_full || i_ex_ready;
  assign w_accept   = i_id_valid && o_id_ready;
  // Entry is stuck in EX this cycle; its operands may go stale unless refreshed.
  assign w_hold     = w_full && !i_ex_ready;

  assign w_rs_addr[0] = r_rs1_addr;
  assign w_rs_addr[1] = r_rs2_addr;
  assign w_rs_data[0] = r_rs1_data;
  assign w_rs_data[1] = r_rs2_data;

  // One bypass mux per source operand (0 = rs1, 1 = rs2).
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    riscv_fwd_mux #(
      .XLEN(XLEN)
    ) u_fwd_mux (
      .i_rs_addr     (w_rs_addr[gi]),
      .i_rs_data     (w_rs_data[gi]),
      .i_mem_rd_addr (i_mem_rd_addr),
      .i_mem_reg_wen (i_mem_reg_wen),
      .i_mem_result  (i_mem_result),
      .i_wb_rd_addr  (i_wb_rd_addr),
      .i_wb_reg_wen  (i_wb_reg_wen),
      .i_wb_result   (i_wb_result),
      .o_data        (w_fwd[gi])
    );
  end

  // Valid FSM: reset > flush > accept > drain > hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
    end else if (i_flush) begin
      r_state <= ST_EMPTY;
    end else if (w_accept) begin
      r_state <= ST_FULL;
    end else if (w_full && i_ex_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  // Payload capture on accept (dropped when flushed), otherwise WB refresh while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd_addr   <= '0;
      r_alu_ctrl  <= ALU_CTRL_ADD;
      r_alu_src_a <= ALU_SRC_A_RS1;
      r_alu_src_b <= ALU_SRC_B_RS2;
      r_reg_wen   <= 1'b0;
    end else if (w_accept && !i_flush) begin
      r_pc        <= i_id_pc;
      r_rs1_data  <= i_id_rs1_data;
      r_rs2_data  <= i_id_rs2_data;
      r_imm       <= i_id_imm;
      r_rs1_addr  <= i_id_rs1_addr;
      r_rs2_addr  <= i_id_rs2_addr;
      r_rd_addr   <= i_id_rd_addr;
      r_alu_ctrl  <= i_id_alu_ctrl;
      r_alu_src_a <= i_id_alu_src_a;
      r_alu_src_b <= i_id_alu_src_b;
      r_reg_wen   <= i_id_reg_wen;
    end else if (w_hold) begin
      // WB retires after this cycle, so bank its value before it disappears.
      if (fwd_hit(i_wb_reg_wen, i_wb_rd_addr, r_rs1_addr)) begin
        r_rs1_data <= i_wb_result;
      end
      if (fwd_hit(i_wb_reg_wen, i_wb_rd_addr, r_rs2_addr)) begin
        r_rs2_data <= i_wb_result;
      end
    end
  end

  assign o_ex_valid    = w_full;
  assign o_alu_a       = (r_alu_src_a == ALU_SRC_A_PC)  ? r_pc  : w_fwd[0];
  assign o_alu_b       = (r_alu_src_b == ALU_SRC_B_IMM) ? r_imm : w_fwd[1];
  assign o_alu_ctrl    = r_alu_ctrl;
  assign o_ex_rs2_data = w_fwd[1];
  assign o_ex_pc       = r_pc;
  assign o_ex_rd_addr  = r_rd_addr;
  assign o_ex_reg_wen  = r_reg_wen && w_full;

endmodule
